// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC, imem request/ready handshake, IF/ID
// pipeline register with a one-entry skid buffer, and branch redirect/flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic        accept;
  logic        redirect;
  logic [31:0] pc_inc;
  logic [31:0] tgt_aligned;

  // Decode can take a word when it is not stalled or IF/ID is empty
  assign accept      = !stall || !valid_q;
  // Branches only flush once fetching has started; in IDLE they just move the PC
  assign redirect    = branch_taken && (state_q != S_IDLE);
  assign pc_inc      = pc_q + 32'd4;
  assign tgt_aligned = {branch_target[31:2], 2'b00};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect always returns to FETCH
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          state_d = S_FETCH;
        end else if (imem_ready && !accept) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect || !stall) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: request is registered and follows the state being entered
  always_comb begin
    req_d = (state_d == S_FETCH);
  end

  // Request register; drops asynchronously on reset to abandon a fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_d;
    end
  end

  // Datapath next-state: PC, IF/ID and skid updates per state
  always_comb begin
    pc_d         = pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    unique case (state_q)
      S_IDLE: begin
        if (branch_taken) begin
          pc_d = tgt_aligned;
        end
      end
      S_FETCH: begin
        if (branch_taken) begin
          pc_d         = tgt_aligned;
          valid_d      = 1'b0;
          instr_d      = '0;
          pc4_d        = '0;
          skid_instr_d = '0;
          skid_pc4_d   = '0;
        end else if (imem_ready) begin
          pc_d = pc_inc;
          if (accept) begin
            instr_d = imem_rdata;
            pc4_d   = pc_inc;
            valid_d = 1'b1;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_inc;
          end
        end else if (!stall) begin
          // Decode consumed the word this cycle and nothing replaces it
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_d         = tgt_aligned;
          valid_d      = 1'b0;
          instr_d      = '0;
          pc4_d        = '0;
          skid_instr_d = '0;
          skid_pc4_d   = '0;
        end else if (!stall) begin
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc4_q        <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc_plus4    = pc4_q;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign funct  = instr_q[5:0];
  assign imm    = instr_q[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a transaction-level model predicts the
// fetch address stream and the ordered words decode must receive.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;

  // Wrap DUT (RESET_PC = FFFF_FFFC)
  logic        w_rst_n;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic        wrap_done;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8C00_0000 | a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .pc_plus4(pc_plus4),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(w_rdata),
    .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
    .instr_valid(w_valid), .instr(w_instr), .pc_plus4(w_pc4),
    .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .funct(w_funct), .imm(w_imm)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: words held in IF/ID then skid, oldest first
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc4;
  } ent_t;
  ent_t sb[$];
  ent_t mon_e;

  // Reference model state (transaction level)
  logic        m_started;
  logic        m_full;
  logic        m_skid;
  logic        m_zero;
  logic [31:0] m_pc;

  task automatic model_reset();
    m_started = 1'b0;
    m_full    = 1'b0;
    m_skid    = 1'b0;
    m_zero    = 1'b1;
    m_pc      = 32'h0;
    sb.delete();
  endtask

  // Monitor: whenever IF/ID is presented, compare with the oldest expected word
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && instr_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL ifid_unexpected: got instr %h pc4 %h, expected no valid word", instr, pc_plus4);
        end else begin
          mon_e = sb[0];
          chk("ifid_word", {instr, pc_plus4}, {mon_e.w, mon_e.pc4});
          chk("ifid_fields", {21'h0, opcode, rs, rt, rd, funct, imm},
              {21'h0, mon_e.w[31:26], mon_e.w[25:21], mon_e.w[20:16],
               mon_e.w[15:11], mon_e.w[5:0], mon_e.w[15:0]});
          if (stall === 1'b0) void'(sb.pop_front());
        end
      end
    end
  end

  // One clock cycle: drive inputs, check handshake vs model, advance model
  task automatic cyc(input logic s, input logic r, input logic b, input logic [31:0] t);
    logic req;
    @(negedge clk);
    stall         = s;
    imem_ready    = r;
    branch_taken  = b;
    branch_target = t;
    #4;
    req = m_started && !m_skid;
    chk("imem_req", {63'h0, imem_req}, {63'h0, req});
    if (req) chk("imem_addr", {32'h0, imem_addr}, {32'h0, m_pc});
    chk("instr_valid", {63'h0, instr_valid}, {63'h0, m_full});
    if (m_zero) chk("ifid_zero", {instr, pc_plus4}, 64'h0);
    if (!m_started) begin
      m_started = 1'b1;
      if (b) m_pc = {t[31:2], 2'b00};
    end else if (b) begin
      m_pc   = {t[31:2], 2'b00};
      m_full = 1'b0;
      m_skid = 1'b0;
      m_zero = 1'b1;
      sb.delete();
    end else if (m_skid) begin
      if (!s) begin
        m_full = 1'b1;
        m_skid = 1'b0;
        m_zero = 1'b0;
      end
    end else if (r) begin
      sb.push_back('{w: mem_word(m_pc), pc4: m_pc + 32'd4});
      if (!m_full || !s) begin
        m_full = 1'b1;
        m_zero = 1'b0;
      end else begin
        m_skid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!s) begin
      m_full = 1'b0;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
  task automatic async_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", {62'h0, imem_req, instr_valid}, 64'h0);
    chk("rst_ifid", {instr, pc_plus4}, 64'h0);
    chk("rst_addr", {32'h0, imem_addr}, 64'h0);
    chk("rst_fields", {21'h0, opcode, rs, rt, rd, funct, imm}, 64'h0);
    @(posedge clk);
    #2;
    stall        = 1'b0;
    imem_ready   = 1'b0;
    branch_taken = 1'b0;
    rst_n        = 1'b1;
    model_reset();
  endtask

  // Wrap-around and async reset on the FFFF_FFFC instance
  initial begin
    wrap_done = 1'b0;
    w_rst_n   = 1'b1;
    #1 w_rst_n = 1'b0;
    #1;
    chk("w_rst", {31'h0, w_req, w_addr}, {32'h0, 32'hFFFF_FFFC});
    @(posedge clk);
    #2 w_rst_n = 1'b1;
    @(negedge clk); #2;
    chk("w_idle_req", {63'h0, w_req}, 64'h0);
    @(negedge clk); #2;
    chk("w_fetch0", {31'h0, w_req, w_addr}, {32'h1, 32'hFFFF_FFFC});
    @(negedge clk); #2;
    chk("w_cap0", {w_instr, w_pc4}, {32'hFFFF_FFFC, 32'h0});
    chk("w_addr1", {31'h0, w_valid, w_addr}, {32'h1, 32'h0});
    @(negedge clk); #2;
    chk("w_cap1", {w_instr, w_pc4}, {32'h8C00_0000, 32'h4});
    #1 w_rst_n = 1'b0;
    #1;
    chk("w_async_ctl", {62'h0, w_req, w_valid}, 64'h0);
    chk("w_async_ifid", {w_instr, w_pc4}, 64'h0);
    chk("w_async_pc", {32'h0, w_addr}, {32'h0, 32'hFFFF_FFFC});
    wrap_done = 1'b1;
  end

  initial begin
    logic s, r, b;
    logic [31:0] t;
    stall         = 1'b0;
    imem_ready    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ctrl", {62'h0, imem_req, instr_valid}, 64'h0);
    chk("reset_ifid", {instr, pc_plus4}, 64'h0);
    chk("reset_fields", {21'h0, opcode, rs, rt, rd, funct, imm}, 64'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Startup with zero-wait memory
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    // Wait states: ready one cycle in three
    for (int i = 0; i < 9; i++) cyc(1'b0, (i % 3) == 2, 1'b0, 32'h0);

    // Stall into HOLD while word @8 returns
    async_reset();
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect with a coincident response
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h43);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect while in HOLD
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 32'h101);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 60);
      b = ($urandom_range(0, 99) < 5);
      t = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 255);
      cyc(s, r, b, t);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++;
    if (wrap_done !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_done: got %b, expected 1", wrap_done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
